// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean level into LFSR-driven contact chatter
// that settles on the requested level after a fixed window of BOUNCE_LEN cycles.
module bounce_gen #(
    parameter int          BOUNCE_LEN = 50000,
    parameter int          SEG_BITS   = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       iCLK,
    input  logic       iRESET_N,
    input  logic       iEN,
    input  logic       iLEVEL,
    output logic       oSW,
    output logic       oBUSY,
    output logic [7:0] oNTOG
);

    localparam int                 WIN_W      = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
    localparam logic [WIN_W-1:0]   WIN_RELOAD = WIN_W'(BOUNCE_LEN - 1);
    localparam logic [15:0]        SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_BOUNCE = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic                target_q, target_d;
    logic [WIN_W-1:0]    win_q,    win_d;
    logic [SEG_BITS-1:0] seg_q,    seg_d;
    logic [15:0]         lfsr_q,   lfsr_d;
    logic                sw_q,     sw_d;
    logic                busy_q,   busy_d;
    logic [7:0]          ntog_q,   ntog_d;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        win_d    = win_q;
        seg_d    = seg_q;
        sw_d     = sw_q;
        busy_d   = busy_q;
        ntog_d   = ntog_q;
        // Left-shifting Fibonacci form; taps 16,14,13,11 are bits 15,13,12,10.
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            ST_STABLE: begin
                if (iEN && (iLEVEL != target_q)) begin
                    state_d  = ST_BOUNCE;
                    target_d = iLEVEL;
                    sw_d     = iLEVEL;
                    win_d    = WIN_RELOAD;
                    seg_d    = lfsr_q[SEG_BITS-1:0];
                    busy_d   = 1'b1;
                    ntog_d   = 8'd1;
                end else if (!iEN) begin
                    sw_d     = iLEVEL;
                    target_d = iLEVEL;
                end
            end
            ST_BOUNCE: begin
                // Settling is checked before the segment so a window never ends on a toggle.
                if (!iEN) begin
                    state_d  = ST_STABLE;
                    sw_d     = iLEVEL;
                    target_d = iLEVEL;
                    busy_d   = 1'b0;
                end else if (iLEVEL != target_q) begin
                    target_d = iLEVEL;
                    win_d    = WIN_RELOAD;
                    seg_d    = lfsr_q[SEG_BITS-1:0];
                end else if (win_q == '0) begin
                    state_d  = ST_STABLE;
                    sw_d     = target_q;
                    busy_d   = 1'b0;
                end else if (seg_q == '0) begin
                    sw_d     = ~sw_q;
                    seg_d    = lfsr_q[SEG_BITS-1:0];
                    ntog_d   = (ntog_q == 8'hFF) ? 8'hFF : ntog_q + 8'd1;
                    win_d    = win_q - WIN_W'(1);
                end else begin
                    win_d    = win_q - WIN_W'(1);
                    seg_d    = seg_q - SEG_BITS'(1);
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state_q  <= ST_STABLE;
            target_q <= 1'b0;
            win_q    <= '0;
            seg_q    <= '0;
            lfsr_q   <= SEED_EFF;
            sw_q     <= 1'b0;
            busy_q   <= 1'b0;
            ntog_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            win_q    <= win_d;
            seg_q    <= seg_d;
            lfsr_q   <= lfsr_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            ntog_q   <= ntog_d;
        end
    end

    assign oSW   = sw_q;
    assign oBUSY = busy_q;
    assign oNTOG = ntog_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: fixed vectors, hand-built corner sequences
// and random stimulus compared every cycle against an event-time reference model.
module tb_bounce_gen;

    localparam int          BL       = 20;
    localparam int          SEGB     = 2;
    localparam logic [15:0] SEEDV    = 16'hACE1;
    localparam int          SEG_MASK = (1 << SEGB) - 1;
    localparam int          TRACE_N  = 25;

    logic       iCLK = 1'b0;
    logic       iRESET_N = 1'b1;
    logic       iEN = 1'b0;
    logic       iLEVEL = 1'b0;
    logic       oSW;
    logic       oBUSY;
    logic [7:0] oNTOG;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: windows and toggles tracked as absolute edge numbers.
    int          cyc = 0;
    int          mBusy, mTarget, mSw, mNtog, mDeadline, mToggleAt;
    logic [15:0] mLfsr;

    bounce_gen #(.BOUNCE_LEN(BL), .SEG_BITS(SEGB), .SEED(SEEDV)) dut (
        .iCLK(iCLK), .iRESET_N(iRESET_N), .iEN(iEN), .iLEVEL(iLEVEL),
        .oSW(oSW), .oBUSY(oBUSY), .oNTOG(oNTOG)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        int x, fb;
        x  = int'(v);
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'(((x << 1) | fb) & 16'hFFFF);
    endfunction

    // Does a window started with this LFSR value land a toggle on its settle edge?
    function automatic bit collides(input logic [15:0] l0);
        logic [15:0] l;
        int nextT;
        l = l0;
        nextT = (int'(l0) & SEG_MASK) + 1;
        for (int k = 1; k <= BL; k++) begin
            l = lfsrStep(l);
            if (k == BL) return (nextT == BL);
            if (k == nextT) nextT = k + (int'(l) & SEG_MASK) + 1;
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        mBusy = 0; mTarget = 0; mSw = 0; mNtog = 0;
        mDeadline = 0; mToggleAt = 0; mLfsr = SEEDV;
    endtask

    task automatic modelStep(input logic en, input logic level);
        int n, lv, s;
        n  = cyc + 1;
        lv = int'(level);
        s  = int'(mLfsr) & SEG_MASK;
        if (mBusy == 0) begin
            if (en && lv != mTarget) begin
                mBusy = 1; mTarget = lv; mSw = lv; mNtog = 1;
                mDeadline = n + BL; mToggleAt = n + s + 1;
            end else if (!en) begin
                mSw = lv; mTarget = lv;
            end
        end else begin
            if (!en) begin
                mBusy = 0; mSw = lv; mTarget = lv;
            end else if (lv != mTarget) begin
                mTarget = lv; mDeadline = n + BL; mToggleAt = n + s + 1;
            end else if (n == mDeadline) begin
                mBusy = 0; mSw = mTarget;
            end else if (n == mToggleAt) begin
                mSw = 1 - mSw;
                mToggleAt = n + s + 1;
                mNtog = (mNtog >= 255) ? 255 : mNtog + 1;
            end
        end
        mLfsr = lfsrStep(mLfsr);
        cyc = n;
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkOutput(input string name);
        testsRun++;
        if (int'(oSW) != mSw || int'(oBUSY) != mBusy || int'(oNTOG) != mNtog) begin
            testsFailed++;
            $display("[TB] FAIL %s: got sw=%0d busy=%0d ntog=%0d, expected sw=%0d busy=%0d ntog=%0d (cycle %0d)",
                     name, oSW, oBUSY, oNTOG, mSw, mBusy, mNtog, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic level);
        iEN = en;
        iLEVEL = level;
        @(posedge iCLK);
        modelStep(en, level);
        #1;
        checkOutput("model");
    endtask

    task automatic doReset(input logic en, input logic level);
        iEN = en;
        iLEVEL = level;
        iRESET_N = 1'b0;
        #1;
        checkValue("async_reset_sw", int'(oSW), 0);
        checkValue("async_reset_busy", int'(oBUSY), 0);
        checkValue("async_reset_ntog", int'(oNTOG), 0);
        modelReset();
        repeat (2) begin
            @(posedge iCLK);
            #1;
            checkOutput("reset_hold");
        end
        iRESET_N = 1'b1;
    endtask

    task automatic recordTrace(output logic [TRACE_N-1:0] tr, output int busyCount);
        tr = '0;
        busyCount = 0;
        for (int k = 0; k < TRACE_N; k++) begin
            applyStimulus(1'b1, 1'b1);
            tr[k] = oSW;
            if (oBUSY) busyCount++;
        end
    endtask

    typedef struct {
        logic en;
        logic level;
        logic expSw;
        logic expBusy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [TRACE_N-1:0] traceA, traceB;
        int busyA, busyB, t0, fellAt, ntogBefore, dFound;
        logic [15:0] probe;
        logic lvl, en;

        vecs[0] = '{en: 1'b0, level: 1'b0, expSw: 1'b0, expBusy: 1'b0};
        vecs[1] = '{en: 1'b0, level: 1'b1, expSw: 1'b1, expBusy: 1'b0};
        vecs[2] = '{en: 1'b0, level: 1'b1, expSw: 1'b1, expBusy: 1'b0};
        vecs[3] = '{en: 1'b0, level: 1'b0, expSw: 1'b0, expBusy: 1'b0};
        vecs[4] = '{en: 1'b0, level: 1'b1, expSw: 1'b1, expBusy: 1'b0};
        vecs[5] = '{en: 1'b1, level: 1'b1, expSw: 1'b1, expBusy: 1'b0};
        vecs[6] = '{en: 1'b1, level: 1'b0, expSw: 1'b0, expBusy: 1'b1};
        vecs[7] = '{en: 1'b0, level: 1'b1, expSw: 1'b1, expBusy: 1'b0};

        #2;
        // Reset held with a pending request, then the first window and its full trace.
        doReset(1'b1, 1'b1);
        recordTrace(traceA, busyA);
        checkValue("first_edge_sw", int'(traceA[0]), 1);
        checkValue("busy_cycles", busyA, BL);
        checkValue("settled_sw", int'(oSW), 1);
        checkValue("ntog_at_least_1", int'(oNTOG >= 8'd1), 1);

        // Bypass pattern and clearing iEN mid-window.
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].en, vecs[i].level);
            checkValue($sformatf("vec%0d_sw", i), int'(oSW), int'(vecs[i].expSw));
            checkValue($sformatf("vec%0d_busy", i), int'(oBUSY), int'(vecs[i].expBusy));
        end

        // Retarget at t0+7 restarts the window: settle at t0+27 on the new level.
        doReset(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        t0 = cyc;
        repeat (6) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        fellAt = -1;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (!oBUSY) begin
                fellAt = cyc;
                break;
            end
        end
        checkValue("retarget_fall_offset", fellAt - t0, 27);
        checkValue("retarget_final_sw", int'(oSW), 0);

        // Settle edge coinciding with an expiring segment.
        doReset(1'b1, 1'b0);
        probe = mLfsr;
        dFound = -1;
        for (int d = 0; d < 256; d++) begin
            if (collides(probe)) begin
                dFound = d;
                break;
            end
            probe = lfsrStep(probe);
        end
        checkValue("collision_found", int'(dFound >= 0), 1);
        if (dFound >= 0) begin
            repeat (dFound) applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b1, 1'b1);
            repeat (BL - 1) applyStimulus(1'b1, 1'b1);
            checkValue("collision_busy_before", int'(oBUSY), 1);
            ntogBefore = int'(oNTOG);
            applyStimulus(1'b1, 1'b1);
            checkValue("collision_busy_after", int'(oBUSY), 0);
            checkValue("collision_sw", int'(oSW), 1);
            checkValue("collision_ntog", int'(oNTOG), ntogBefore);
        end

        // Reset mid-window, then replay must reproduce the first trace.
        doReset(1'b1, 1'b1);
        repeat (11) applyStimulus(1'b1, 1'b1);
        checkValue("midwin_busy_before_reset", int'(oBUSY), 1);
        doReset(1'b1, 1'b1);
        recordTrace(traceB, busyB);
        checkValue("replay_trace", int'(traceB), int'(traceA));
        checkValue("replay_busy_cycles", busyB, BL);

        // Random traffic against the model.
        doReset(1'b1, 1'b0);
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) lvl = ~lvl;
            en = ($urandom_range(0, 99) >= 5);
            if ($urandom_range(0, 1499) == 0) doReset(en, lvl);
            applyStimulus(en, lvl);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Switch-bounce emulator: takes a clean, synchronous level and produces a chattering switch signal that settles after a fixed window. It is the stimulus-side counterpart of the team's switch debouncer. It sits between a test driver (bench or on-board pattern source) and the debouncer's switch input, giving repeatable, LFSR-driven contact bounce for simulation and hardware demos.

## Interface
- BOUNCE_LEN, 50000: bounce window length in clock cycles (1 ms at 50 MHz); legal range 2..2^20.
- SEG_BITS, 8: width of the random segment length; segments last 1..2^SEG_BITS cycles.
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- iRESET_N  input  1  asynchronous, active-low reset.
- iEN  input  1  bounce enable; 0 = bypass (output follows iLEVEL with 1-cycle latency).
- iLEVEL  input  1  clean requested switch level; synchronous to iCLK, not synchronized internally.
- oSW  output  1  emulated bouncing switch output (registered).
- oBUSY  output  1  high while a bounce window is active (registered).
- oNTOG  output  8  toggle count of the current or most recent window, saturating at 255.

## Operation
- Free-running LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle including in bypass. Reset value is SEED.
- Registers: state (STABLE/BOUNCE), target, win counter (ceil(log2 BOUNCE_LEN) bits), seg counter (SEG_BITS bits), oSW, oBUSY, oNTOG.
- STABLE state:
  - oSW equals target.
  - If iEN=1 and iLEVEL != target: go to BOUNCE, then target<=iLEVEL, oSW<=iLEVEL, win<=BOUNCE_LEN-1, seg<=lfsr[SEG_BITS-1:0], oBUSY<=1, oNTOG<=1.
- BOUNCE state, evaluated in this priority order each cycle:
  - iEN=0: go to STABLE, then oSW<=iLEVEL, target<=iLEVEL, oBUSY<=0.
  - iLEVEL != target (retarget): target<=iLEVEL, win<=BOUNCE_LEN-1, seg reloaded from the LFSR, oSW unchanged, oNTOG kept.
  - win==0: go to STABLE, then oSW<=target, oBUSY<=0. Settling wins over a simultaneous seg==0.
  - seg==0: oSW<=~oSW, seg<=lfsr[SEG_BITS-1:0], oNTOG<=sat(oNTOG+1), win decrements.
  - Otherwise: win and seg decrement.
- Bypass (iEN=0 in STABLE): oSW<=iLEVEL and target<=iLEVEL every cycle; oBUSY stays 0.
- An iLEVEL pulse that returns to target before being sampled produces no window.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state=STABLE, target=0, oSW=0, oBUSY=0, oNTOG=0, win=0, seg=0, LFSR=SEED.
- Window start:
  - iLEVEL change sampled at edge t0 gives oSW=new level and oBUSY=1 after t0.
  - oBUSY stays high for exactly BOUNCE_LEN cycles; it falls after edge t0+BOUNCE_LEN-1+1 = t0+BOUNCE_LEN.
  - oSW equals target from t0+BOUNCE_LEN onward.
- Segments:
  - A segment loaded with value s toggles oSW s+1 cycles later.
  - Minimum spacing between toggles is 1 cycle (s=0).
- Retarget: restarts the full BOUNCE_LEN window from the retarget edge.
- Reset mid-window: all outputs return to reset values immediately; no settle is emitted.
- Sequence: fully deterministic for a given SEED and stimulus, so a bench reference model must match bit-for-bit.

## Test plan
Bench parameters: BOUNCE_LEN=20, SEG_BITS=2, SEED=16'hACE1.
- Reset: hold iRESET_N=0 with iLEVEL=1 and iEN=1 -> oSW=0, oBUSY=0, oNTOG=0; after release, a window starts on the first edge.
- Rising request from 0, iEN=1 -> oSW=1 on t0; toggles match the LFSR model; oBUSY high exactly 20 cycles; oSW=1 from t0+20; oNTOG equals the model count (at least 1).
- Retarget: raise iLEVEL at t0, drop it at t0+7 -> target=0; oBUSY stays high until t0+27; final oSW=0.
- Collision: force win==0 and seg==0 on the same cycle (pick a seed from the model) -> oSW=target, no extra toggle, oNTOG not incremented.
- Bypass: iEN=0, iLEVEL pattern 0,1,1,0 -> oSW shows the same pattern delayed one cycle, oBUSY=0 throughout; clearing iEN mid-window ends it next edge with oSW=iLEVEL.
- Reset mid-window: assert iRESET_N=0 at t0+10 -> oSW=0 and oBUSY=0 asynchronously; the LFSR restarts at 16'hACE1, and the toggle sequence after re-release matches the first run.
